// File: rtl/edge_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_pkg
// Description : Shared event-mode type, mode constants and qualification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_event_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    function automatic logic qualify_evt(input logic rise, input logic fall, input mode_t mode);
        return (rise & mode[0]) | (fall & mode[1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_chan.sv
`default_nettype none
// ============================================================================
// Module      : edge_chan
// Description : One channel: synchronizer, debounce filter, edge pulses,
//               sticky flag and saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_chan
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 4,
    parameter int CNT_W       = 16,
    parameter bit INIT_LVL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  mode_t            mode,
    input  logic             flag_clr,
    input  logic             cnt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             evt,
    output logic             evt_flag,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int                FCNT_W      = $clog2(FILT_CNT) + 1;
    localparam logic [FCNT_W-1:0] c_FILT_LAST = FCNT_W'(FILT_CNT - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FCNT_W-1:0]      r_fcnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_evt;
    logic                   r_flag;
    logic [CNT_W-1:0]       r_cnt;

    logic w_sync;
    logic w_differ;
    logic w_take;
    logic w_rise_nxt;
    logic w_fall_nxt;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_differ   = (w_sync != r_level);
    assign w_take     = w_differ && (r_fcnt == c_FILT_LAST);
    assign w_rise_nxt = w_take & w_sync;
    assign w_fall_nxt = w_take & ~w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_LVL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig};
        end
    end

    // Count consecutive differing cycles; any agreeing cycle restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt  <= '0;
            r_level <= INIT_LVL;
        end else begin
            if (!w_differ || w_take) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
            if (w_take) begin
                r_level <= w_sync;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_evt  <= qualify_evt(w_rise_nxt, w_fall_nxt, mode);
        end
    end

    // Flag and counter consume the registered pulse, so a clear arriving in the
    // pulse cycle loses to the pending set/increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_flag <= r_evt | (r_flag & ~flag_clr);
            if (cnt_clr) begin
                r_cnt <= CNT_W'(r_evt);
            end else if (r_evt && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level    = r_level;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign evt      = r_evt;
    assign evt_flag = r_flag;
    assign evt_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/edge_event_filter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_filter
// Description : Multi-channel debounced edge-event detector with interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_filter
    import edge_event_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 4,
    parameter int CNT_W       = 16,
    parameter bit INIT_LVL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       sig,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       flag_clr,
    input  logic [CH-1:0]       cnt_clr,
    input  logic [CH-1:0]       irq_en,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       rise,
    output logic [CH-1:0]       fall,
    output logic [CH-1:0]       evt,
    output logic [CH-1:0]       evt_flag,
    output logic [CNT_W*CH-1:0] evt_cnt,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CNT    (FILT_CNT),
            .CNT_W       (CNT_W),
            .INIT_LVL    (INIT_LVL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig      (sig[i]),
            .mode     (mode[2*i +: 2]),
            .flag_clr (flag_clr[i]),
            .cnt_clr  (cnt_clr[i]),
            .level    (level[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .evt      (evt[i]),
            .evt_flag (evt_flag[i]),
            .evt_cnt  (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign irq = |(evt_flag & irq_en);

endmodule
`default_nettype wire

// File: doc/edge_event_filter.md
EDGE_EVENT_FILTER -- requirements
Module: edge_event_filter

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (2..4).
REQ-003 Parameter FILT_CNT, default 4, consecutive stable cycles before filtered level changes (1..255; 1 = no filtering).
REQ-004 Parameter CNT_W, default 16, width of per-channel event counter.
REQ-005 Parameter INIT_LVL, default 0, reset value of synchronizer and filtered level.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 sig  in  CH  asynchronous raw inputs, one bit per channel.
REQ-009 mode  in  2*CH  per-channel event mode: 00 off, 01 rise, 10 fall, 11 both.
REQ-010 flag_clr  in  CH  write-1-to-clear for sticky flags, sampled each cycle.
REQ-011 cnt_clr  in  CH  synchronous clear of per-channel counter.
REQ-012 irq_en  in  CH  per-channel interrupt mask.
REQ-013 level  out  CH  filtered, debounced level.
REQ-014 rise  out  CH  one-cycle pulse on filtered 0->1 transition.
REQ-015 fall  out  CH  one-cycle pulse on filtered 1->0 transition.
REQ-016 evt  out  CH  one-cycle pulse: rise or fall qualified by mode.
REQ-017 evt_flag  out  CH  sticky event flags.
REQ-018 evt_cnt  out  CNT_W*CH  per-channel saturating event counts, channel n at bits [n*CNT_W +: CNT_W].
REQ-019 irq  out  1  OR over channels of evt_flag AND irq_en.

Function
REQ-020 Each sig bit SHALL pass through SYNC_STAGES flops before any use; no raw sig reaches logic.
REQ-021 Filter: per-channel counter SHALL increment while synchronized value differs from level and reset to 0 on any cycle they match.
REQ-022 level SHALL take the synchronized value at the edge where the counter reaches FILT_CNT-1 while still differing; counter returns to 0.
REQ-023 rise/fall SHALL be registered, asserted for exactly the one cycle following the level update edge; never both in one cycle.
REQ-024 Latency: new value first sampled at edge 0 and held stable -> level and rise/fall visible after edge SYNC_STAGES+FILT_CNT-1.
REQ-025 Glitch shorter than FILT_CNT synchronized cycles SHALL produce no level change and no pulse.
REQ-026 evt = (rise AND mode[0]) OR (fall AND mode[1]), same cycle as rise/fall; mode change effective from next edge; flags and counts unaffected by mode change.
REQ-027 evt_flag sets on evt; flag_clr clears; set and clear same cycle -> flag stays set.
REQ-028 evt_cnt increments by 1 per evt, saturates at 2^CNT_W-1; cnt_clr with evt same cycle -> count = 1; cnt_clr alone -> 0.
REQ-029 irq combinational from registered evt_flag and irq_en, no added latency.

Reset
REQ-030 rst_n low SHALL asynchronously force: sync flops and level = INIT_LVL, filter counters 0, rise/fall/evt 0, evt_flag 0, evt_cnt 0, hence irq 0.
REQ-031 Reset mid-filter SHALL discard the pending transition; no pulse on release.
REQ-032 Input differing from INIT_LVL at reset release SHALL be treated as a new transition after REQ-024 latency.

Structure
REQ-033 Shared package edge_event_pkg holds mode constants (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the 2-bit mode type.
REQ-034 Sub-module edge_chan (synchronizer, filter, rise/fall detect, flag, counter) instantiated CH times via generate; top holds only slicing and irq reduction.
REQ-035 Filter counter width = clog2(FILT_CNT)+1, derived locally.

Verification
REQ-036 Defaults, mode=01 ch0, sig[0] 0->1 at edge 0 held -> rise[0], evt[0] high one cycle after edge 5; evt_flag[0]=1, evt_cnt[0]=1.
REQ-037 sig[1] high-pulse 3 cycles (FILT_CNT=4) -> no level change, no rise/fall/evt on ch1.
REQ-038 mode=11, 3 clean toggles on ch2 -> 2 rise + 1 fall pulses, evt_cnt[2]=3; mode=00 -> rise/fall pulse, evt stays 0.
REQ-039 flag_clr[0] same cycle as evt[0] -> flag stays 1; irq_en[0]=1 -> irq=1; next flag_clr alone -> flag 0, irq 0.
REQ-040 CNT_W=2, 5 events on ch3 -> evt_cnt[3]=3 saturated; cnt_clr with event -> 1.
REQ-041 rst_n low 2 cycles into filter window -> all outputs 0 immediately, no pulse after release if sig returns to INIT_LVL.
